// File: rtl/div_bf16.sv
// div_bf16: multi-cycle bf16 divider using restoring division (10 quotient bits).
// Operands are captured on the accepting edge. The result and flags are registered
// on the edge that raises done.
// Optional feature macro: DIV_BF16_RNE_EN selects round-to-nearest-even.
// When the macro is undefined, the divider truncates.
// Subnormal inputs are flushed to zero.
module div_bf16 (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] bf1_in,
  input  logic [15:0] bf2_in,
  output logic [15:0] bf_out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StDiv, StRound} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [8:0]  rem_q, rem_d;
  logic [9:0]  quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bf_out_q, bf_out_d;
  logic [3:0]  flags_q, flags_d;  // {overflow, underflow, invalid, div_by_zero}
  logic        busy_q, busy_d, done_q, done_d;

  logic [7:0]  mant_b;
  logic [8:0]  diff;
  logic [15:0] res;
  logic [3:0]  res_flags;

  assign mant_b = {1'b1, b_q[6:0]};
  assign diff   = rem_q - {1'b0, mant_b};

  // Operand classification and normalise/round of the finished quotient
  logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [6:0]  mant;
  logic        grd, stk, inc;
  logic [7:0]  mant_sum;
  logic signed [10:0] exp_raw, exp_fin;

  // Result datapath: specials take priority over the normalised quotient
  always_comb begin
    sign   = a_q[15] ^ b_q[15];
    a_zero = (a_q[14:7] == 8'd0);
    b_zero = (b_q[14:7] == 8'd0);
    a_inf  = (a_q[14:7] == 8'hFF) && (a_q[6:0] == 7'd0);
    b_inf  = (b_q[14:7] == 8'hFF) && (b_q[6:0] == 7'd0);
    a_nan  = (a_q[14:7] == 8'hFF) && (a_q[6:0] != 7'd0);
    b_nan  = (b_q[14:7] == 8'hFF) && (b_q[6:0] != 7'd0);

    if (quo_q[9]) begin
      mant = quo_q[8:2];
      grd  = quo_q[1];
      stk  = quo_q[0] | (rem_q != 9'd0);
    end else begin
      mant = quo_q[7:1];
      grd  = quo_q[0];
      stk  = (rem_q != 9'd0);
    end
`ifdef DIV_BF16_RNE_EN
    inc = grd & (stk | mant[0]);
`else
    inc = grd & stk & 1'b0;  // truncation never increments
`endif
    mant_sum = {1'b0, mant} + {7'd0, inc};
    // A quotient below 1.0 needs one extra exponent decrement.
    exp_raw  = $signed({3'b000, a_q[14:7]}) - $signed({3'b000, b_q[14:7]})
             + 11'sd126 + $signed({10'd0, quo_q[9]});
    exp_fin  = exp_raw + $signed({10'd0, mant_sum[7]});

    res       = 16'd0;
    res_flags = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res       = 16'h7FC0;
      res_flags = 4'b0010;
    end else if (b_zero) begin
      res = {sign, 8'hFF, 7'd0};
      if (!a_inf) res_flags = 4'b0001;
    end else if (a_inf) begin
      res = {sign, 8'hFF, 7'd0};
    end else if (a_zero || b_inf) begin
      res = {sign, 15'd0};
    end else if (exp_fin >= 11'sd255) begin
      res       = {sign, 8'hFF, 7'd0};
      res_flags = 4'b1000;
    end else if (exp_fin <= 11'sd0) begin
      res       = {sign, 15'd0};
      res_flags = 4'b0100;
    end else begin
      res = {sign, exp_fin[7:0], mant_sum[6:0]};
    end
  end

  // FSM next-state: accept, iterate one quotient bit per cycle, then publish
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    bf_out_d = bf_out_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = bf1_in;
          b_d     = bf2_in;
          rem_d   = {2'b01, bf1_in[6:0]};
          quo_d   = 10'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (rem_q >= {1'b0, mant_b}) begin
          rem_d = diff << 1;
          quo_d = {quo_q[8:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[8:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = StRound;
      end
      StRound: begin
        bf_out_d = res;
        flags_d  = res_flags;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q  <= StIdle;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      rem_q    <= 9'd0;
      quo_q    <= 10'd0;
      cnt_q    <= 4'd0;
      bf_out_q <= 16'd0;
      flags_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      bf_out_q <= bf_out_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bf_out      = bf_out_q;
  assign overflow    = flags_q[3];
  assign underflow   = flags_q[2];
  assign invalid     = flags_q[1];
  assign div_by_zero = flags_q[0];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_div_bf16.sv
// Scoreboard bench for div_bf16.
// Drivers push expected results, and a negedge monitor pops and checks them on done.
module tb_div_bf16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bf1_in = 16'd0, bf2_in = 16'd0;
  logic [15:0] bf_out;
  logic        overflow, underflow, invalid, div_by_zero, busy, done;

  div_bf16 dut (
    .clk        (clk),
    .nRST       (nRST),
    .start      (start),
    .bf1_in     (bf1_in),
    .bf2_in     (bf2_in),
    .bf_out     (bf_out),
    .overflow   (overflow),
    .underflow  (underflow),
    .invalid    (invalid),
    .div_by_zero(div_by_zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] exp;  // {ovf, unf, inv, dbz, result}
    int          acc;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: quotient from integer division of the significands
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    int  ea, eb, ma, mb, q, r, e, mant;
    bit  s, g, st, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[6:0] == 0);
    ib = (eb == 255) && (b[6:0] == 0);
    na = (ea == 255) && (a[6:0] != 0);
    nb = (eb == 255) && (b[6:0] != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {4'b0010, 16'h7FC0};
    if (zb) return ia ? {4'b0000, s, 15'h7F80} : {4'b0001, s, 15'h7F80};
    if (ia) return {4'b0000, s, 15'h7F80};
    if (za || ib) return {4'b0000, s, 15'h0000};
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    q  = (ma * 512) / mb;
    r  = (ma * 512) % mb;
    if (q >= 512) begin
      mant = (q >> 2) & 127;
      g    = q[1];
      st   = q[0] || (r != 0);
      e    = ea - eb + 127;
    end else begin
      mant = (q >> 1) & 127;
      g    = q[0];
      st   = (r != 0);
      e    = ea - eb + 126;
    end
`ifdef DIV_BF16_RNE_EN
    if (g && (st || (mant % 2 == 1))) mant = mant + 1;
`endif
    if (mant == 128) begin
      mant = 0;
      e    = e + 1;
    end
    if (e >= 255) return {4'b1000, s, 15'h7F80};
    if (e <= 0) return {4'b0100, s, 15'h0000};
    return {4'b0000, s, e[7:0], mant[6:0]};
  endfunction

  function automatic logic [15:0] rand_bf();
    int          k;
    logic [15:0] v;
    k = $urandom_range(0, 9);
    v = 16'($urandom);
    if (k == 0) v[14:7] = 8'h00;
    else if (k == 1) begin
      v[14:7] = 8'hFF;
      v[6:0]  = 7'd0;
    end else if (k == 2) begin
      v[14:7] = 8'hFF;
      v[6:0]  = 7'($urandom_range(1, 127));
    end else v[14:7] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // Issue one operation; leaves the caller at the edge that raises done
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [19:0] e,
                       input bit hold);
    item_t it;
    @(negedge clk);
    bf1_in = a;
    bf2_in = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    it.a = a; it.b = b; it.exp = e; it.acc = cyc;
    sb.push_back(it);
    if (!hold) start = 1'b0;
    bf1_in = 16'($urandom);
    bf2_in = 16'($urandom);
    repeat (11) @(posedge clk);
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    item_t it;
    if (nRST && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
      end else begin
        it = sb.pop_front();
        check($sformatf("result %h/%h", it.a, it.b), 32'(bf_out), 32'(it.exp[15:0]));
        check($sformatf("flags %h/%h", it.a, it.b),
              32'({overflow, underflow, invalid, div_by_zero}), 32'(it.exp[19:16]));
        check("latency", 32'(cyc - it.acc), 32'd11);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    bit          h;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({bf_out, overflow, underflow, invalid, div_by_zero, busy, done}),
          32'd0);
    nRST = 1'b1;

    // Directed values
    do_op(16'h4040, 16'h4000, {4'b0000, 16'h3FC0}, 1'b0);
`ifdef DIV_BF16_RNE_EN
    do_op(16'h3F80, 16'h4040, {4'b0000, 16'h3EAB}, 1'b0);
`else
    do_op(16'h3F80, 16'h4040, {4'b0000, 16'h3EAA}, 1'b0);
`endif
    do_op(16'h3F80, 16'h0000, {4'b0001, 16'h7F80}, 1'b0);
    do_op(16'h0000, 16'h0000, {4'b0010, 16'h7FC0}, 1'b0);
    do_op(16'hFF80, 16'h4000, {4'b0000, 16'hFF80}, 1'b0);
    do_op(16'h7F00, 16'h3F00, {4'b1000, 16'h7F80}, 1'b0);
    do_op(16'h0080, 16'h4000, {4'b0100, 16'h0000}, 1'b0);

    // Start re-pulsed at acceptance+3 must be ignored
    begin
      item_t it;
      @(negedge clk);
      bf1_in = 16'h4040;
      bf2_in = 16'h4000;
      start  = 1'b1;
      @(posedge clk);
      #1;
      it.a = 16'h4040; it.b = 16'h4000; it.exp = {4'b0000, 16'h3FC0}; it.acc = cyc;
      sb.push_back(it);
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("busy_mid_op", 32'(busy), 32'd1);
      start  = 1'b1;
      bf1_in = 16'h3F80;
      bf2_in = 16'h0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
    end

    // Start held high: back-to-back operations
    do_op(16'h4040, 16'h4000, {4'b0000, 16'h3FC0}, 1'b1);
    do_op(16'hC000, 16'h3F80, {4'b0000, 16'hC000}, 1'b1);
    do_op(16'h4000, 16'hC000, {4'b0000, 16'hBF80}, 1'b0);

    // Reset at acceptance+5 aborts without a done pulse
    @(negedge clk);
    bf1_in = 16'h4040;
    bf2_in = 16'h4000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    nRST = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_op", 32'({bf_out, overflow, underflow, invalid, div_by_zero, busy, done}),
          32'd0);
    nRST = 1'b1;
    repeat (15) @(posedge clk);
    do_op(16'h3F80, 16'h0000, {4'b0001, 16'h7F80}, 1'b0);

    // Randomised operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = rand_bf();
      rb = rand_bf();
      h  = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op(ra, rb, model(ra, rb), h);
    end

    repeat (20) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
